ntt_pointwise_mul: RTL and testbench

Pointwise modular multiplier for the NTT-domain polynomial product: after the NTT wrapper has left two transformed coefficient vectors in BRAM, this block reads A[i] and B[i], computes C[i] = A[i]·B[i] mod P, and writes C back into the same BRAM for the inverse-NTT pass. It sits directly downstream of the NTT/BRAM wrapper. It shares that wrapper's single-port BRAM interface: 64-bit data, byte address = word index << 2.

---
 rtl/ntt_pointwise_mul_if.sv | 33 +++
 rtl/ntt_pointwise_mul.sv | 201 ++++++++++++++++++++
 tb/tb_ntt_pointwise_mul.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pointwise_mul_if.sv
// ntt_pointwise_mul_if
// Bundles the start/busy/done handshake with the single-port BRAM bus that
// the pointwise multiplier shares with the NTT wrapper.
//   start      : one-cycle request into the multiplier
//   busy, done : run status out of the multiplier
//   BRAM_addr  : 13-bit byte address (word index << 2)
//   BRAM_clk   : forwarded clock for the BRAM port
//   BRAM_din   : 64-bit write data
//   BRAM_dout  : 64-bit read data, valid one cycle after the address
//   BRAM_en    : port enable
//   BRAM_we    : write enable
// master = the multiplier, slave = the BRAM / controller side.
interface ntt_pointwise_mul_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [12:0] BRAM_addr;
  logic        BRAM_clk;
  logic [63:0] BRAM_din;
  logic [63:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_we;

  modport master (
    input  start, BRAM_dout,
    output busy, done, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we
  );

  modport slave (
    output start, BRAM_dout,
    input  busy, done, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_we
  );
endinterface

// File: rtl/ntt_pointwise_mul.sv
// ntt_pointwise_mul
// For i = 0..N-1 reads A[i] and B[i] from the shared BRAM, computes
// C[i] = A[i]*B[i] mod P (Goldilocks prime) and writes C[i] back.
// Each element takes RDA, RDB, CAPB, MUL_LAT x MUL, WR = 4+MUL_LAT cycles;
// a one-cycle DONE state pulses done afterwards.
// Ports:
//   clk : clock, BRAM_clk is a copy of it
//   rst : asynchronous active-high reset
//   bus : handshake + BRAM master port (see ntt_pointwise_mul_if)
// All bus outputs are registered; each transition loads the output values
// that belong to the state being entered.
module ntt_pointwise_mul #(
  parameter int          N       = 64,
  parameter int          A_BASE  = 64,
  parameter int          B_BASE  = 128,
  parameter int          C_BASE  = 192,
  parameter logic [63:0] P       = 64'hFFFF_FFFF_0000_0001,
  parameter int          MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  ntt_pointwise_mul_if.master bus
);

  localparam int CW = $clog2(N) + 1;
  localparam int LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MUL_LAT - 1);
  localparam logic [10:0]   A_W      = 11'(A_BASE);
  localparam logic [10:0]   B_W      = 11'(B_BASE);
  localparam logic [10:0]   C_W      = 11'(C_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_CAPB,
    S_MUL,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] i_q;
  logic [LW-1:0] lat_q;
  logic [63:0]   op_a_q;
  logic [63:0]   op_b_q;
  logic          busy_q;
  logic          done_q;
  logic [12:0]   addr_q;
  logic [63:0]   din_q;
  logic          en_q;
  logic          we_q;

  logic [127:0]  prod_now;
  logic [63:0]   mul_res;

  function automatic logic [12:0] byte_addr(input logic [10:0] base,
                                            input logic [CW-1:0] idx);
    logic [10:0] word;
    word = base + 11'(idx);
    return {word, 2'b00};
  endfunction

  // Goldilocks folding: with x = hh*2^96 + hl*2^64 + lo,
  // 2^64 = 2^32-1 and 2^96 = -1 (mod P), so x = lo + hl*(2^32-1) - hh.
  // Adding P keeps the sum non-negative; it then lies in [0, 3P), so at
  // most two conditional subtractions give the canonical result < P.
  // This folding is only valid for P = 2^64 - 2^32 + 1.
  function automatic logic [63:0] gl_reduce(input logic [127:0] x);
    logic [66:0] w;
    logic [66:0] p1;
    logic [66:0] p2;
    logic [66:0] r;
    p1 = {3'b000, P};
    p2 = {2'b00, P, 1'b0};
    w  = {3'b000, x[63:0]}
       + {3'b000, x[95:64], 32'h0000_0000}
       - {35'h0, x[95:64]}
       + p1
       - {35'h0, x[127:96]};
    if (w >= p2) begin
      r = w - p2;
    end else if (w >= p1) begin
      r = w - p1;
    end else begin
      r = w;
    end
    return r[63:0];
  endfunction

  assign prod_now = {64'h0, op_a_q} * {64'h0, op_b_q};

  // With one MUL cycle the whole multiply+reduce is a single path; with
  // more, the product is registered on the first MUL edge so the reduction
  // gets its own stage (operands are stable for the whole MUL phase).
  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign mul_res = gl_reduce(prod_now);
    end else begin : g_latn
      logic [127:0] prod_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_q <= '0;
        end else if (state_q == S_MUL) begin
          prod_q <= prod_now;
        end
      end
      assign mul_res = gl_reduce(prod_q);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      lat_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      // Port is idle unless the state being entered drives it; din_q is
      // deliberately not defaulted so it keeps the last written value.
      done_q <= 1'b0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            i_q     <= '0;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            addr_q  <= byte_addr(A_W, '0);
            state_q <= S_RDA;
          end
        end
        S_RDA: begin
          en_q    <= 1'b1;
          addr_q  <= byte_addr(B_W, i_q);
          state_q <= S_RDB;
        end
        S_RDB: begin
          // A[i] was addressed in RDA and is on dout now.
          op_a_q  <= bus.BRAM_dout;
          state_q <= S_CAPB;
        end
        S_CAPB: begin
          op_b_q  <= bus.BRAM_dout;
          lat_q   <= LAT_INIT;
          state_q <= S_MUL;
        end
        S_MUL: begin
          if (lat_q == '0) begin
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= byte_addr(C_W, i_q);
            din_q   <= mul_res;
            state_q <= S_WR;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_WR: begin
          if (i_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            i_q     <= i_q + 1'b1;
            en_q    <= 1'b1;
            addr_q  <= byte_addr(A_W, i_q + 1'b1);
            state_q <= S_RDA;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.BRAM_addr = addr_q;
  assign bus.BRAM_clk  = clk;
  assign bus.BRAM_din  = din_q;
  assign bus.BRAM_en   = en_q;
  assign bus.BRAM_we   = we_q;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Bench for ntt_pointwise_mul: instance 0 uses the defaults (N=64,
// MUL_LAT=2), instance 1 uses N=2, MUL_LAT=4. Each has its own BRAM model.
// Expected writes (address, C value from a*b mod P) are queued when the
// operands are loaded; a monitor per instance pops them on every write.
module tb_ntt_pointwise_mul;
  localparam logic [63:0] P    = 64'hFFFF_FFFF_0000_0001;
  localparam logic [63:0] SENT = 64'hDEAD_BEEF_0000_0000;

  typedef struct packed {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [2][2048];
  wr_t         exp_q [2][$];
  int          exp_done_edge [2] = '{-1, -1};
  int          wr_count [2] = '{0, 0};
  logic        start_s [2] = '{1'b0, 1'b0};

  logic        busy_w [2];
  logic        done_w [2];
  logic        en_w   [2];
  logic        we_w   [2];
  logic        bclk_w [2];
  logic [12:0] addr_w [2];
  logic [63:0] din_w  [2];

  function automatic int n_of(int id);
    return (id == 0) ? 64 : 2;
  endfunction

  function automatic int lat_of(int id);
    return (id == 0) ? 2 : 4;
  endfunction

  function automatic logic [63:0] ref_mulmod(logic [63:0] a, logic [63:0] b);
    logic [127:0] pr;
    pr = {64'h0, a} * {64'h0, b};
    pr = pr % {64'h0, P};
    return pr[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_u
    localparam int GN = (gi == 0) ? 64 : 2;
    localparam int GL = (gi == 0) ? 2 : 4;

    ntt_pointwise_mul_if bus ();

    ntt_pointwise_mul #(
      .N(GN), .A_BASE(64), .B_BASE(128), .C_BASE(192), .P(P), .MUL_LAT(GL)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.start  = start_s[gi];
    assign busy_w[gi] = bus.busy;
    assign done_w[gi] = bus.done;
    assign en_w[gi]   = bus.BRAM_en;
    assign we_w[gi]   = bus.BRAM_we;
    assign bclk_w[gi] = bus.BRAM_clk;
    assign addr_w[gi] = bus.BRAM_addr;
    assign din_w[gi]  = bus.BRAM_din;

    // Single-port BRAM: synchronous read, data one cycle after the address.
    always @(posedge bus.BRAM_clk) begin
      if (bus.BRAM_en) begin
        if (bus.BRAM_we) mem[gi][bus.BRAM_addr[12:2]] = bus.BRAM_din;
        else bus.BRAM_dout <= mem[gi][bus.BRAM_addr[12:2]];
      end
    end

    wr_t e;
    always @(negedge clk) begin
      if (!rst) begin
        if (bus.BRAM_we) begin
          wr_count[gi]++;
          chk("write_expected", 64'(exp_q[gi].size() != 0), 64'd1);
          if (exp_q[gi].size() != 0) begin
            e = exp_q[gi].pop_front();
            $display("inst%0d write addr=%0d data=%h", gi, bus.BRAM_addr, bus.BRAM_din);
            chk("wr_addr", 64'(bus.BRAM_addr), 64'(e.addr));
            chk("wr_data", bus.BRAM_din, e.data);
          end
        end
        if (!bus.busy) chk("idle_port_quiet", 64'({bus.BRAM_en, bus.BRAM_we}), 64'd0);
        if (bus.done) begin
          $display("inst%0d done at edge %0d", gi, cyc);
          chk("done_edge", 64'(cyc), 64'(exp_done_edge[gi]));
          chk("write_count", 64'(wr_count[gi]), 64'(GN));
          chk("queue_drained", 64'(exp_q[gi].size()), 64'd0);
          exp_done_edge[gi] = -1;
        end
      end
    end
  end

  // mode 0: scale (A=i+1, B=2); mode 1: modular corner values; mode 2: random.
  task automatic load(int id, int mode);
    logic [63:0] a;
    logic [63:0] b;
    for (int i = 0; i < n_of(id); i++) begin
      a = rand64();
      b = rand64();
      if (mode == 0) begin
        a = 64'(i + 1);
        b = 64'd2;
      end else if (mode == 1) begin
        case (i)
          0: begin a = P - 64'd1; b = P - 64'd1; end
          1: begin a = 64'h1_0000_0000; b = 64'h1_0000_0000; end
          2: a = 64'd0;
          3: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; end
          4: a = P;
          default: ;
        endcase
      end
      mem[id][64 + i]  = a;
      mem[id][128 + i] = b;
      mem[id][192 + i] = SENT ^ 64'(i);
      exp_q[id].push_back('{addr: 13'((192 + i) * 4), data: ref_mulmod(a, b)});
    end
  endtask

  task automatic launch(int id);
    @(negedge clk);
    start_s[id] = 1'b1;
    wr_count[id] = 0;
    exp_done_edge[id] = cyc + 1 + n_of(id) * (4 + lat_of(id));
    @(negedge clk);
    start_s[id] = 1'b0;
    chk("busy_after_start", 64'(busy_w[id]), 64'd1);
  endtask

  task automatic wait_done(int id);
    int lim;
    bit seen;
    lim = n_of(id) * (4 + lat_of(id)) + 40;
    seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = done_w[id];
    end
    chk("done_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic wait_edge(int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic outs_zero(int id);
    chk("rst_busy", 64'(busy_w[id]), 64'd0);
    chk("rst_done", 64'(done_w[id]), 64'd0);
    chk("rst_en", 64'(en_w[id]), 64'd0);
    chk("rst_we", 64'(we_w[id]), 64'd0);
    chk("rst_addr", 64'(addr_w[id]), 64'd0);
    chk("rst_din", din_w[id], 64'd0);
  endtask

  initial begin
    int se;
    repeat (3) @(negedge clk);
    outs_zero(0);
    outs_zero(1);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    outs_zero(0);
    chk("bram_clk_hi", 64'(bclk_w[0]), 64'(clk));

    // Scale run with stray starts at cycles 10 and 200 of the run.
    load(0, 0);
    launch(0);
    se = cyc;
    wait_edge(se + 9);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_edge(se + 199);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0);
    chk("scale_c0", mem[0][192], 64'd2);
    chk("scale_c63", mem[0][255], 64'd128);

    // start held from the DONE cycle into the following IDLE cycle: only
    // the IDLE sample may launch the second run.
    load(0, 1);
    start_s[0] = 1'b1;
    wr_count[0] = 0;
    exp_done_edge[0] = cyc + 2 + 64 * 6;
    @(negedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0);
    chk("wrap_pm1_sq", mem[0][192], 64'd1);
    chk("wrap_2p32_sq", mem[0][193], 64'h0000_0000_FFFF_FFFF);
    chk("wrap_zero", mem[0][194], 64'd0);
    chk("non_reduced", mem[0][195], 64'h0000_0000_FFFF_FFFE);
    chk("operand_eq_p", mem[0][196], 64'd0);

    // Reset in cycle 100 of a run: element 16 is mid-multiply.
    load(0, 2);
    launch(0);
    se = cyc;
    wait_edge(se + 99);
    #1;
    rst = 1'b1;
    #1;
    outs_zero(0);
    chk("pending_after_reset", 64'(exp_q[0].size()), 64'd48);
    exp_q[0].delete();
    exp_done_edge[0] = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 16; i < 64; i++) chk("c_untouched", mem[0][192 + i], SENT ^ 64'(i));
    chk("idle_after_reset", 64'(busy_w[0]), 64'd0);

    // Fresh random run after the reset.
    load(0, 2);
    launch(0);
    wait_done(0);

    // Small instance: N=2, MUL_LAT=4.
    load(1, 1);
    launch(1);
    wait_done(1);
    chk("small_c0", mem[1][192], 64'd1);
    chk("small_c1", mem[1][193], 64'h0000_0000_FFFF_FFFF);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
